// File: rtl/cache_lookup_ctrl_pkg.sv
// Shared types and constants for the cache lookup controller.
// The package holds the controller state enum, the default geometry and the
// helpers that derive tag width and line count from that geometry.
// Port summary: none, because this file is a package.
package cache_lookup_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_WAIT,
        REFILL,
        FILL_DONE
    } ctrl_state_t;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_INDEX_WIDTH = 4;
    localparam int TAG_WIDTH       = DEF_ADDR_WIDTH - DEF_INDEX_WIDTH;
    localparam int NUM_LINES       = 2 ** DEF_INDEX_WIDTH;

    function automatic int tag_width(input int addr_width, input int index_width);
        return addr_width - index_width;
    endfunction

    function automatic int num_lines(input int index_width);
        return 2 ** index_width;
    endfunction

endpackage

// File: rtl/cache_lookup_ctrl_if.sv
// CPU-side request bus and the strobes the controller sends to logic_we.
// master: CPU or testbench side. It drives cpu_req, cpu_we, cpu_addr and flush.
// slave:  cache_lookup_ctrl side. It drives cpu_ready, done, hit, re, we,
//         line_addr, hit_cnt and miss_cnt.
interface cache_lookup_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  flush;
    logic                  cpu_ready;
    logic                  done;
    logic                  hit;
    logic                  re;
    logic                  we;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [CNT_WIDTH-1:0]  hit_cnt;
    logic [CNT_WIDTH-1:0]  miss_cnt;

    modport master (
        output cpu_req, cpu_we, cpu_addr, flush,
        input  cpu_ready, done, hit, re, we, line_addr, hit_cnt, miss_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, flush,
        output cpu_ready, done, hit, re, we, line_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_lookup_ctrl_tag_store.sv
// Direct-mapped tag and valid arrays.
// Ports: clk, rst (async, active-high); clear drops every valid bit in one
// cycle; wr_en/wr_addr installs the tag of wr_addr and sets its valid bit;
// rd_addr/rd_hit is a combinational tag compare for rd_addr.
module cache_lookup_ctrl_tag_store
    import cache_lookup_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_hit
);
    localparam int TAG_W   = tag_width(ADDR_WIDTH, INDEX_WIDTH);
    localparam int N_LINES = num_lines(INDEX_WIDTH);

    logic [N_LINES-1:0] valid;
    logic [TAG_W-1:0]   tags [N_LINES];

    logic [INDEX_WIDTH-1:0] wr_idx;
    logic [INDEX_WIDTH-1:0] rd_idx;
    assign wr_idx = wr_addr[INDEX_WIDTH-1:0];
    assign rd_idx = rd_addr[INDEX_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < N_LINES; i++) tags[i] <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
            tags[wr_idx]  <= wr_addr[ADDR_WIDTH-1:INDEX_WIDTH];
        end
    end

    assign rd_hit = valid[rd_idx] && (tags[rd_idx] == rd_addr[ADDR_WIDTH-1:INDEX_WIDTH]);

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Request sequencer that sits in front of logic_we. It takes one CPU request
// at a time, does the tag lookup and, on a read miss, waits out the RAM read
// latency before it pulses the refill strobe.
// Ports: clk, rst (async, active-high), bus (cache_lookup_ctrl_if.slave).
// The hit/re/we/done outputs are registered. They are computed at the edge
// that enters a state, so they are valid throughout that state.
module cache_lookup_ctrl
    import cache_lookup_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int RAM_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    cache_lookup_ctrl_if.slave  bus
);
    localparam logic [3:0] LAT_LOAD = (RAM_LATENCY > 0) ? 4'(RAM_LATENCY - 1) : 4'd0;

    ctrl_state_t           state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_lat;
    logic [3:0]            lat_cnt;
    logic                  hit_q, re_q, we_q, done_q;
    logic [CNT_WIDTH-1:0]  hit_cnt, miss_cnt;
    logic                  lookup_hit;

    // The compare runs on the incoming address while the FSM is in IDLE, so
    // the registered hit is ready when LOOKUP is entered.
    cache_lookup_ctrl_tag_store #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_tag_store (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE && bus.flush),
        .wr_en   (state == FILL_DONE),
        .wr_addr (addr_q),
        .rd_addr (bus.cpu_addr),
        .rd_hit  (lookup_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            we_lat   <= 1'b0;
            lat_cnt  <= '0;
            hit_q    <= 1'b0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            hit_q  <= 1'b0;
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.flush && bus.cpu_req) begin
                        state  <= LOOKUP;
                        addr_q <= bus.cpu_addr;
                        we_lat <= bus.cpu_we;
                        hit_q  <= lookup_hit;
                        we_q   <= bus.cpu_we;
                        re_q   <= !bus.cpu_we && lookup_hit;
                        done_q <= bus.cpu_we || lookup_hit;
                    end
                end
                LOOKUP: begin
                    if (hit_q) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                    end
                    if (we_lat || hit_q) begin
                        state <= IDLE;
                    end else if (RAM_LATENCY == 0) begin
                        state <= REFILL;
                        re_q  <= 1'b1;
                    end else begin
                        state   <= MISS_WAIT;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                MISS_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= REFILL;
                        re_q  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                REFILL: begin
                    state  <= FILL_DONE;
                    done_q <= 1'b1;
                end
                FILL_DONE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ready = (state == IDLE) && !bus.flush;
    assign bus.done      = done_q;
    assign bus.hit       = hit_q;
    assign bus.re        = re_q;
    assign bus.we        = we_q;
    assign bus.line_addr = addr_q;
    assign bus.hit_cnt   = hit_cnt;
    assign bus.miss_cnt  = miss_cnt;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Testbench for cache_lookup_ctrl. The counters are 2 bits wide so that
// saturation is reached. Expected behaviour comes from a transaction-level
// model of the cache made of valid/tag arrays and counts.
module tb_cache_lookup_ctrl;
    localparam int AW = 8;
    localparam int IW = 4;
    localparam int L  = 2;
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_lookup_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    cache_lookup_ctrl #(
        .ADDR_WIDTH  (AW),
        .INDEX_WIDTH (IW),
        .RAM_LATENCY (L),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    bit       vld_m [16];
    bit [3:0] tag_m [16];
    int       hits_m, miss_m;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            vld_m[i] = 1'b0;
            tag_m[i] = 4'd0;
        end
        hits_m = 0;
        miss_m = 0;
    endtask

    task automatic do_req(input bit w, input logic [7:0] a);
        int       idx;
        bit       h;
        int       len;
        logic [4:0] exp;
        idx = int'(a[3:0]);
        h   = vld_m[idx] && (tag_m[idx] == a[7:4]);
        len = (w || h) ? 1 : L + 3;
        @(negedge clk);
        chk("idle_ready", bus.cpu_ready, 1);
        chk("idle_strobes", {bus.hit, bus.re, bus.we, bus.done}, 0);
        chk("hit_cnt", bus.hit_cnt, hits_m);
        chk("miss_cnt", bus.miss_cnt, miss_m);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = w;
        bus.cpu_addr = a;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            exp[4] = 1'b0;
            exp[3] = (k == 1) && h;
            exp[2] = ((k == 1) && !w && h) || (!w && !h && (k == L + 2));
            exp[1] = (k == 1) && w;
            exp[0] = (k == len);
            chk("busy_rdy_hit_re_we_done", {bus.cpu_ready, bus.hit, bus.re, bus.we, bus.done}, exp);
            chk("line_addr", bus.line_addr, a);
            // Requests presented while the controller is busy must be ignored.
            bus.cpu_req  = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.cpu_we   = 1'($urandom_range(0, 1));
            bus.cpu_addr = 8'($urandom);
        end
        bus.cpu_req = 1'b0;
        if (h) hits_m = sat_inc(hits_m);
        else   miss_m = sat_inc(miss_m);
        if (!w && !h) begin
            vld_m[idx] = 1'b1;
            tag_m[idx] = a[7:4];
        end
    endtask

    task automatic do_flush(input bit with_req);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.cpu_req  = with_req;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'($urandom);
        #1;
        chk("flush_ready", bus.cpu_ready, 0);
        @(negedge clk);
        chk("flush_strobes", {bus.hit, bus.re, bus.we, bus.done}, 0);
        bus.flush   = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        chk("post_flush_ready", bus.cpu_ready, 1);
        for (int i = 0; i < 16; i++) vld_m[i] = 1'b0;
    endtask

    task automatic do_reset_mid(input logic [7:0] a);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = a;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rdy_hit_re_we_done", {bus.cpu_ready, bus.hit, bus.re, bus.we, bus.done}, 5'b10000);
        chk("rst_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);
        chk("rst_line_addr", bus.line_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst          = 1'b1;
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = '0;
        bus.flush    = 1'b0;
        model_reset();
        #12;
        chk("reset_rdy_hit_re_we_done", {bus.cpu_ready, bus.hit, bus.re, bus.we, bus.done}, 5'b10000);
        chk("reset_line_addr", bus.line_addr, 0);
        chk("reset_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_req(1'b0, 8'h35);
        do_req(1'b0, 8'h35);
        do_req(1'b0, 8'h45);
        do_req(1'b0, 8'h35);
        do_req(1'b0, 8'h45);
        do_req(1'b1, 8'h45);
        do_req(1'b1, 8'h99);
        do_req(1'b0, 8'h99);
        do_flush(1'b1);
        do_req(1'b0, 8'h45);
        do_reset_mid(8'h35);
        do_req(1'b0, 8'h45);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                do_flush(1'($urandom_range(0, 1)));
            end else if (r < 6) begin
                do_reset_mid(8'($urandom));
            end else begin
                do_req(1'($urandom_range(0, 2) == 0),
                       {4'($urandom_range(0, 3)), 4'($urandom)});
            end
        end

        @(negedge clk);
        chk("final_hit_cnt", bus.hit_cnt, hits_m);
        chk("final_miss_cnt", bus.miss_cnt, miss_m);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
